spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_slave_if.sv | 33 +++
 rtl/spi_shift_reg.sv | 44 ++++
 rtl/spi_slave.sv | 142 ++++++++++++++
 tb/tb_spi_slave.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg : shared SPI word width and slave FSM state encoding          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_if : SPI serial pins plus word-level tx/rx handshake        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) ();

  logic              ss;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              abort;

  modport slave (
    input  ss, MOSI, tx_data, tx_load,
    output MISO, tx_ready, rx_data, rx_valid, abort
  );

  modport master (
    output ss, MOSI, tx_data, tx_load,
    input  MISO, tx_ready, rx_data, rx_valid, abort
  );

endinterface
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_shift_reg : MSB-first shift register with parallel load           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_data_i,
  input  wire logic             shift_i,
  input  wire logic             serial_i,
  output logic      [WIDTH-1:0] q_o,
  output logic                  serial_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Parallel load takes priority over shifting on the same edge.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[WIDTH-2:0], serial_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o      = data_q;
  assign serial_o = data_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave : clk-synchronous SPI slave, one bit per clk while ss=0     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input wire logic   clk,
  input wire logic   rst_n,
  spi_slave_if.slave bus
);

  localparam int              CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              full_q, full_d;

  logic              w_active;
  logic              w_first;
  logic              w_last;
  logic [DATA_W-1:0] w_rx_q;
  logic              w_rx_serial;
  logic [DATA_W-1:0] w_tx_q;
  logic              w_tx_serial;
  logic [DATA_W-1:0] w_tx_seed;
  logic              w_unused;

  assign w_active = !bus.ss;
  assign w_first  = (bit_cnt_q == '0);
  assign w_last   = (bit_cnt_q == C_LAST);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_active) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_active) begin
          state_d = ST_IDLE;
          abort_d = !w_first;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_active) begin
      if (w_last) begin
        bit_cnt_d  = '0;
        rx_data_d  = {w_rx_q[DATA_W-2:0], bus.MOSI};
        rx_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else begin
      bit_cnt_d = '0;
    end
  end

  // A word boundary always drains the buffer; a load only lands when it was empty.
  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (w_active && w_first) begin
      full_d = 1'b0;
    end
    if (bus.tx_load && !full_q) begin
      buf_d  = bus.tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
    end
  end

  spi_shift_reg #(.WIDTH(DATA_W)) u_rx_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (w_active),
    .serial_i    (bus.MOSI),
    .q_o         (w_rx_q),
    .serial_o    (w_rx_serial)
  );

  // The MSB goes out directly from the buffer on the first bit, so the shifter keeps the rest.
  assign w_tx_seed = full_q ? {buf_q[DATA_W-2:0], 1'b0} : '0;

  spi_shift_reg #(.WIDTH(DATA_W)) u_tx_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (w_active && w_first),
    .load_data_i (w_tx_seed),
    .shift_i     (w_active),
    .serial_i    (1'b0),
    .q_o         (w_tx_q),
    .serial_o    (w_tx_serial)
  );

  assign bus.MISO     = !w_active ? 1'b0 :
                        (w_first ? (full_q & buf_q[DATA_W-1]) : w_tx_serial);
  assign bus.tx_ready = !full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.abort    = abort_q;

  assign w_unused = ^{w_rx_q[DATA_W-1], w_rx_serial, w_tx_q};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_slave : randomized scoreboard bench for spi_slave              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_spi_slave;

  localparam int W = spi_pkg::SPI_DATA_W;

  typedef struct packed {
    logic         is_abort;
    logic [W-1:0] data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(W)) bus ();

  spi_slave #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Word-level reference: what the master should see bit by bit, and which events follow.
  logic exp_miso[$];
  logic exp_ready[$];
  ev_t  ev_q[$];
  int           pos;
  logic [W-1:0] rx_acc;
  logic [W-1:0] cur_tx;
  logic [W-1:0] model_buf;
  logic         model_full;
  logic [W-1:0] last_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_miso.delete();
    exp_ready.delete();
    ev_q.delete();
    pos        = 0;
    rx_acc     = '0;
    cur_tx     = '0;
    model_buf  = '0;
    model_full = 1'b0;
    last_rx    = '0;
  endtask

  task automatic cycle(input logic ss_v, input logic mosi_v, input logic load_v,
                       input logic [W-1:0] d_v);
    logic pre_full;
    ev_t  ev;
    @(negedge clk);
    bus.ss      = ss_v;
    bus.MOSI    = mosi_v;
    bus.tx_load = load_v;
    bus.tx_data = d_v;
    pre_full    = model_full;
    exp_ready.push_back(!pre_full);
    if (!ss_v) begin
      if (pos == 0) begin
        cur_tx     = pre_full ? model_buf : '0;
        model_full = 1'b0;
      end
      exp_miso.push_back(cur_tx[W-1-pos]);
      rx_acc = W'(2 * rx_acc + mosi_v);
      pos++;
      if (pos == W) begin
        pos     = 0;
        last_rx = rx_acc;
        ev.is_abort = 1'b0;
        ev.data     = rx_acc;
        ev_q.push_back(ev);
      end
    end else begin
      exp_miso.push_back(1'b0);
      if (pos != 0) begin
        pos = 0;
        ev.is_abort = 1'b1;
        ev.data     = last_rx;
        ev_q.push_back(ev);
      end
    end
    if (load_v && !pre_full) begin
      model_buf  = d_v;
      model_full = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic load(input logic [W-1:0] v);
    cycle(1'b1, 1'b0, 1'b1, v);
  endtask

  task automatic frame(input logic [W-1:0] word, input int nbits, input int load_at,
                       input logic [W-1:0] load_val);
    for (int i = 0; i < nbits; i++) cycle(1'b0, word[W-1-i], (i == load_at), load_val);
  endtask

  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    repeat (ncyc) @(negedge clk);
    bus.ss      = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_load = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor samples just before each rising edge.
  initial begin
    logic em, er;
    ev_t  ev;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b0) begin
        check("rst_miso",     32'(bus.MISO),     32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_abort",    32'(bus.abort),    32'd0);
        check("rst_rx_data",  32'(bus.rx_data),  32'd0);
      end else begin
        if (exp_miso.size() > 0) begin
          em = exp_miso.pop_front();
          check("miso", 32'(bus.MISO), 32'(em));
        end
        if (exp_ready.size() > 0) begin
          er = exp_ready.pop_front();
          check("tx_ready", 32'(bus.tx_ready), 32'(er));
        end
        if (bus.rx_valid === 1'b1 || bus.abort === 1'b1) begin
          check("valid_abort_excl", 32'(bus.rx_valid & bus.abort), 32'd0);
          if (ev_q.size() == 0) begin
            check("unexpected_event", 32'({bus.rx_valid, bus.abort}), 32'd0);
          end else begin
            ev = ev_q.pop_front();
            check("event_is_abort", 32'(bus.abort), 32'(ev.is_abort));
            check("rx_data", 32'(bus.rx_data), 32'(ev.data));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int           len;
    int           gap;
    logic [W-1:0] word;
    bus.ss      = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    idle(2);
    load(8'hA5);
    frame(8'hB2, W, -1, '0);
    idle(2);

    load(8'h55);
    frame(8'h0F, W, 2, 8'h3C);
    frame(8'hF0, W, -1, '0);
    idle(2);

    frame(8'hE7, 5, -1, '0);
    idle(2);
    frame(8'h81, W, -1, '0);
    idle(2);

    frame(8'h6D, W, -1, '0);
    idle(1);
    load(8'hC3);
    load(8'h99);
    frame(8'h12, W, -1, '0);
    idle(2);

    load(8'h77);
    frame(8'hAA, 4, -1, '0);
    apply_reset(2);
    frame(8'h5A, W, -1, '0);
    idle(2);

    for (int f = 0; f < 60; f++) begin
      len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W - 1)) : W;
      word = W'($urandom);
      for (int i = 0; i < len; i++)
        cycle(1'b0, word[W-1-i], ($urandom_range(0, 3) == 0), W'($urandom));
      if (len != W || $urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++)
          cycle(1'b1, 1'b0, ($urandom_range(0, 2) == 0), W'($urandom));
      end
    end
    idle(3);

    check("pending_events", 32'(ev_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
